// File: rtl/q12_pkg.sv
// ---------------------------------------------------------------------------
// q12_pkg
// Shared constants, types and helpers for the masked (2-share DOM) inverse
// of the Q12 quadratic map.
//
// Contents:
//   SHARES      - number of Boolean shares per variable (2)
//   NIBBLE_W    - width of one share of x / y (4)
//   IDX_A..X0   - bit positions inside a nibble: [3]=a, [2]=x2, [1]=x1, [0]=x0
//                 (the result uses the same positions for a, b, c, d)
//   RND_W       - width of the fresh-randomness input
//   RND_AT/AX2  - which rnd bit feeds which AND gadget
//   nibble_t    - one 4-bit share
//   compress_share - share-wise stage-2 compression of one share
// ---------------------------------------------------------------------------
package q12_pkg;

  localparam int SHARES   = 2;
  localparam int NIBBLE_W = 4;

  localparam int IDX_A  = 3;
  localparam int IDX_X2 = 2;
  localparam int IDX_X1 = 1;
  localparam int IDX_X0 = 0;

  localparam int RND_W   = 2;
  localparam int RND_AT  = 0;
  localparam int RND_AX2 = 1;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Combine one share of the registered linear terms with the same share of
  // both AND gadget outputs.  Only one share index ever enters this function,
  // so calling it once per share keeps the two shares apart.
  //   b_i = x2_i ^ (a&t)_i
  //   c_i = x1_i ^ (a&x2)_i
  //   a_i and d_i pass straight through.
  function automatic nibble_t compress_share(input nibble_t lin,
                                             input logic    at_prod,
                                             input logic    ax2_prod);
    nibble_t y;
    y         = lin;
    y[IDX_X2] = lin[IDX_X2] ^ at_prod;
    y[IDX_X1] = lin[IDX_X1] ^ ax2_prod;
    return y;
  endfunction

endpackage : q12_pkg

// File: rtl/q12_inv_dom_and2.sv
// ---------------------------------------------------------------------------
// dom_and2
// Two-share DOM-independent AND gadget.  Computes shares of (a & b) from
// shares (a1,a2) and (b1,b2) using one fresh random bit r.
//
// The two cross products are blinded with the same r and registered before
// they are ever combined with the inner products; the register stops glitches
// from carrying unmasked information into the compression XOR.  Compression
// itself is left combinational on the outputs so the parent can fold it into
// its own output register.
//
// Ports:
//   clk      - clock, rising edge
//   rst_i    - synchronous active-high reset, clears all four registers
//   en       - load enable (the parent's input-accept strobe)
//   a1, a2   - shares of operand a
//   b1, b2   - shares of operand b
//   r        - fresh random bit, sampled only when en is high
//   q1, q2   - shares of a & b (valid one cycle after the enabled load)
// ---------------------------------------------------------------------------
module dom_and2 (
  input  logic clk,
  input  logic rst_i,
  input  logic en,
  input  logic a1,
  input  logic a2,
  input  logic b1,
  input  logic b2,
  input  logic r,
  output logic q1,
  output logic q2
);

  logic inner1_q;
  logic inner2_q;
  logic cross12_q;
  logic cross21_q;

  // Stage-1 capture: inner products stay within a share; each cross product
  // touches one share of a and the other share of b, and is masked by r
  // before the flop so no single net ever holds an unmasked cross term.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      inner1_q  <= 1'b0;
      inner2_q  <= 1'b0;
      cross12_q <= 1'b0;
      cross21_q <= 1'b0;
    end else if (en) begin
      inner1_q  <= a1 & b1;
      inner2_q  <= a2 & b2;
      cross12_q <= (a1 & b2) ^ r;
      cross21_q <= (a2 & b1) ^ r;
    end
  end

  // Compression: the two r's cancel when q1 and q2 are recombined.
  assign q1 = inner1_q ^ cross12_q;
  assign q2 = inner2_q ^ cross21_q;

endmodule : dom_and2

// File: rtl/q12_inv_dom.sv
// ---------------------------------------------------------------------------
// q12_inv_dom
// Two-share masked inverse of the Q12 quadratic map with a valid/ready
// pipeline of two register stages.
//
// Unmasked function (x = in1^in2, y = out1^out2):
//   a = x3, d = x0, t = x2^x1, b = x2 ^ (a&t), c = x1 ^ (a&x2)
//   y = {a, b, c, d}
//
// Ports:
//   clk      - clock, rising edge
//   rst_i    - synchronous active-high reset
//   in1/in2  - shares of x, bits [3:0] = a, x2, x1, x0
//   rnd      - fresh randomness: rnd[0] for a&t, rnd[1] for a&x2
//   valid_i  - input beat present
//   ready_o  - block accepts an input this cycle
//   out1/out2- shares of y, bits [3:0] = a, b, c, d
//   valid_o  - output beat present
//   ready_i  - downstream accepts the output
//
// Pipeline: stage 1 holds the linear shares plus the gadget registers;
// stage 2 is the out1/out2 register.  Latency is two cycles from accept.
// ---------------------------------------------------------------------------
module q12_inv_dom
  import q12_pkg::*;
(
  input  logic                clk,
  input  logic                rst_i,
  input  logic [NIBBLE_W-1:0] in1,
  input  logic [NIBBLE_W-1:0] in2,
  input  logic [RND_W-1:0]    rnd,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [NIBBLE_W-1:0] out1,
  output logic [NIBBLE_W-1:0] out2,
  output logic                valid_o,
  input  logic                ready_i
);

  nibble_t             share_in [SHARES];
  nibble_t             lin_q    [SHARES];
  nibble_t             y_sh     [SHARES];
  logic [SHARES-1:0]   a_sh;
  logic [SHARES-1:0]   x2_sh;
  logic [SHARES-1:0]   t_sh;
  logic [SHARES-1:0]   at_sh;
  logic [SHARES-1:0]   ax2_sh;
  logic                s1_valid;
  logic                adv2;
  logic                accept;

  assign share_in[0] = in1;
  assign share_in[1] = in2;

  // Linear layer, strictly per share: each bit of a_sh/x2_sh/t_sh depends on
  // exactly one input share.
  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      a_sh[i]  = share_in[i][IDX_A];
      x2_sh[i] = share_in[i][IDX_X2];
      t_sh[i]  = share_in[i][IDX_X2] ^ share_in[i][IDX_X1];
    end
  end

  // Handshake.  Stage 2 may move when it is empty or being drained; stage 1
  // may move when it is empty or stage 2 is taking its content.  ready_o is
  // built only from registers and ready_i, never from valid_i.
  assign adv2    = !valid_o || ready_i;
  assign ready_o = !s1_valid || adv2;
  assign accept  = valid_i && ready_o;

  // Nonlinear layer: two DOM gadgets.  Their internal flops are the stage-1
  // registers for the products; rnd is consumed only on accept.
  dom_and2 u_and_at (
    .clk   (clk),
    .rst_i (rst_i),
    .en    (accept),
    .a1    (a_sh[0]),
    .a2    (a_sh[1]),
    .b1    (t_sh[0]),
    .b2    (t_sh[1]),
    .r     (rnd[RND_AT]),
    .q1    (at_sh[0]),
    .q2    (at_sh[1])
  );

  dom_and2 u_and_ax2 (
    .clk   (clk),
    .rst_i (rst_i),
    .en    (accept),
    .a1    (a_sh[0]),
    .a2    (a_sh[1]),
    .b1    (x2_sh[0]),
    .b2    (x2_sh[1]),
    .r     (rnd[RND_AX2]),
    .q1    (ax2_sh[0]),
    .q2    (ax2_sh[1])
  );

  // Stage 1: linear pass-through shares and the stage-1 valid flag.  The
  // share registers only load on accept so idle cycles do not toggle them.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < SHARES; i++) begin
        lin_q[i] <= '0;
      end
    end else begin
      if (ready_o) begin
        s1_valid <= accept;
      end
      if (accept) begin
        for (int i = 0; i < SHARES; i++) begin
          lin_q[i] <= share_in[i];
        end
      end
    end
  end

  // Share-wise compression feeding the output register.
  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      y_sh[i] = compress_share(lin_q[i], at_sh[i], ax2_sh[i]);
    end
  end

  // Stage 2: output register.  Frozen while valid_o is held against a low
  // ready_i; otherwise takes whatever stage 1 holds.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      out1    <= '0;
      out2    <= '0;
    end else if (adv2) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        out1 <= y_sh[0];
        out2 <= y_sh[1];
      end
    end
  end

endmodule : q12_inv_dom

// File: tb/tb_q12_inv_dom.sv
// ---------------------------------------------------------------------------
// tb_q12_inv_dom
// Directed self-checking bench for q12_inv_dom.  Inputs change just after the
// falling edge; outputs are sampled at the falling edge before any change.
// ---------------------------------------------------------------------------
module tb_q12_inv_dom;

  logic       clk;
  logic       rst_i;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [1:0] rnd;
  logic       valid_i;
  logic       ready_o;
  logic [3:0] out1;
  logic [3:0] out2;
  logic       valid_o;
  logic       ready_i;

  int tests_run;
  int tests_failed;

  q12_inv_dom dut (
    .clk     (clk),
    .rst_i   (rst_i),
    .in1     (in1),
    .in2     (in2),
    .rnd     (rnd),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .out1    (out1),
    .out2    (out2),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed inverse-Q12 table for x = 0..15.
  logic [3:0] inv_table [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                 4'h8, 4'h9, 4'hE, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD};

  // Forward Q12 map, solved independently from the inverse equations:
  // x2 = b ^ (a&c), x1 = c ^ (a&(b^c)).
  function automatic logic [3:0] fwd_q12(input logic [3:0] y);
    logic a, b, c, d;
    a = y[3]; b = y[2]; c = y[1]; d = y[0];
    return {a, b ^ (a & c), c ^ (a & (b ^ c)), d};
  endfunction

  task automatic drive_idle();
    valid_i = 1'b0;
    in1     = 4'h0;
    in2     = 4'h0;
    rnd     = 2'b00;
  endtask

  task automatic drive_beat(input logic [3:0] x, input logic [3:0] sh1, input logic [1:0] r);
    valid_i = 1'b1;
    in1     = sh1;
    in2     = sh1 ^ x;
    rnd     = r;
  endtask

  task automatic test_reset();
    // Reset with a beat offered at the same time: reset must win.
    @(negedge clk);
    rst_i = 1'b1;
    drive_beat(4'hE, 4'h6, 2'b11);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid_o: got %b, expected 0", valid_o);
    end
    tests_run++;
    if ({out1, out2} !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_outs: got %h/%h, expected 0/0", out1, out2);
    end
    rst_i = 1'b0;
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready_o: got %b, expected 1", ready_o);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (valid_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_no_accept cycle %0d: valid_o got %b, expected 0", k, valid_o);
      end
    end
  endtask

  task automatic test_known_vector();
    // x=1110 as in1=0110, in2=1000, rnd=11 -> y=1100.
    @(negedge clk);
    ready_i = 1'b1;
    valid_i = 1'b1;
    in1     = 4'b0110;
    in2     = 4'b1000;
    rnd     = 2'b11;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL known_ready_o: got %b, expected 1", ready_o);
    end
    @(negedge clk);
    drive_idle();
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL known_latency1: valid_o got %b, expected 0", valid_o);
    end
    @(negedge clk);
    tests_run++;
    if (valid_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL known_latency2: valid_o got %b, expected 1", valid_o);
    end
    tests_run++;
    if ((out1 ^ out2) !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL known_y: got %b, expected 1100", out1 ^ out2);
    end
    @(negedge clk);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL known_drain: valid_o got %b, expected 0", valid_o);
    end
  endtask

  task automatic test_identity();
    // a=0 makes the map the identity: x=0101 -> y=0101 for any split.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_beat(4'b0101, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      tests_run++;
      if (valid_o !== 1'b1 || (out1 ^ out2) !== 4'b0101) begin
        tests_failed++;
        $display("[TB] FAIL identity %0d: got valid=%b y=%b, expected valid=1 y=0101",
                 k, valid_o, out1 ^ out2);
      end
    end
  endtask

  task automatic test_rnd_sweep();
    // x=1011 under every rnd value -> y=1111.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      drive_beat(4'b1011, 4'($urandom_range(0, 15)), 2'(r));
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      tests_run++;
      if (valid_o !== 1'b1 || (out1 ^ out2) !== 4'b1111) begin
        tests_failed++;
        $display("[TB] FAIL rnd_sweep rnd=%0d: got valid=%b y=%b, expected valid=1 y=1111",
                 r, valid_o, out1 ^ out2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int out_idx;
    logic [3:0] y;
    out_idx = 0;
    ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        y = out1 ^ out2;
        if (out_idx < 16) begin
          tests_run++;
          if (y !== inv_table[out_idx]) begin
            tests_failed++;
            $display("[TB] FAIL b2b_y beat %0d: got %h, expected %h", out_idx, y, inv_table[out_idx]);
          end
          tests_run++;
          if (fwd_q12(y) !== 4'(out_idx)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_fwd beat %0d: got %h, expected %h", out_idx, fwd_q12(y), out_idx);
          end
        end else begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL b2b_extra: got beat %0d, expected 16 beats only", out_idx);
        end
        out_idx++;
      end
      if (c < 16) begin
        drive_beat(4'(c), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        #1;
        tests_run++;
        if (ready_o !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL b2b_ready cycle %0d: got %b, expected 1", c, ready_o);
        end
      end else begin
        drive_idle();
      end
    end
    tests_run++;
    if (out_idx !== 16) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d, expected 16", out_idx);
    end
  endtask

  task automatic test_backpressure();
    // A=1110 (y=1100), B=1011 (y=1111), C=0101 (y=0101).
    @(negedge clk);
    ready_i = 1'b0;
    drive_beat(4'b1110, 4'h3, 2'b01);
    @(negedge clk);
    drive_beat(4'b1011, 4'h9, 2'b10);
    @(negedge clk);
    drive_beat(4'b0101, 4'hC, 2'b11);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (ready_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stall_ready cycle %0d: got %b, expected 0", k, ready_o);
      end
      tests_run++;
      if (valid_o !== 1'b1 || (out1 ^ out2) !== 4'b1100) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold cycle %0d: got valid=%b y=%b, expected valid=1 y=1100",
                 k, valid_o, out1 ^ out2);
      end
      @(negedge clk);
    end
    ready_i = 1'b1;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_release_ready: got %b, expected 1", ready_o);
    end
    @(negedge clk);
    drive_idle();
    tests_run++;
    if (valid_o !== 1'b1 || (out1 ^ out2) !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL stall_beat_b: got valid=%b y=%b, expected valid=1 y=1111",
               valid_o, out1 ^ out2);
    end
    @(negedge clk);
    tests_run++;
    if (valid_o !== 1'b1 || (out1 ^ out2) !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL stall_beat_c: got valid=%b y=%b, expected valid=1 y=0101",
               valid_o, out1 ^ out2);
    end
    @(negedge clk);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_drain: valid_o got %b, expected 0", valid_o);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    ready_i = 1'b1;
    drive_beat(4'hF, 4'h5, 2'b01);
    @(negedge clk);
    drive_idle();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    tests_run++;
    if (valid_o !== 1'b0 || out1 !== 4'h0 || out2 !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clear: got valid=%b out1=%h out2=%h, expected 0/0/0",
               valid_o, out1, out2);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL midreset_dropped cycle %0d: got valid=%b ready=%b, expected 0/1",
                 k, valid_o, ready_o);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b1;
    ready_i      = 1'b1;
    drive_idle();

    test_reset();
    test_known_vector();
    test_identity();
    test_rnd_sweep();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_q12_inv_dom
